// File: rtl/wq_mem_bist_pkg.sv
// rtl/wq_mem_bist_pkg.sv - March C- element table, states and background constants for the Wq SRAM BIST
// WQ_BIST_CHKBD_EN adds a second, checkerboard-background pass and widens the element tag.
package wq_mem_bist_pkg;

  typedef enum logic [1:0] {IDLE, MARCH, DRAIN, DONE} state_t;

  localparam int NUM_ELEM = 6;
  localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEM - 1);

  // Bit i describes element Mi; bits 6-7 are padding so a 3-bit index never runs off the end.
  localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;
  localparam logic [7:0] ELEM_HAS_RD = 8'b0011_1110;
  localparam logic [7:0] ELEM_HAS_WR = 8'b0001_1111;
  localparam logic [7:0] ELEM_RD_INV = 8'b0001_0100;
  localparam logic [7:0] ELEM_WR_INV = 8'b0000_1010;

`ifdef WQ_BIST_CHKBD_EN
  localparam int ELEM_W = 4;
`else
  localparam int ELEM_W = 3;
`endif

  // Replicated to full width: even words read 0xAA..A, odd words 0x55..5.
  localparam logic [1:0] CHKBD_EVEN = 2'b10;
  localparam logic [1:0] CHKBD_ODD  = 2'b01;

endpackage

// File: rtl/wq_mem_bist_if.sv
// rtl/wq_mem_bist_if.sv - BIST-mode port of the Wq weight SRAM macro (active-low controls)
interface wq_mem_bist_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 128
);
  logic              BIST;
  logic              CEBM;
  logic              WEBM;
  logic [ADDR_W-1:0] AM;
  logic [DATA_W-1:0] DM;
  logic [DATA_W-1:0] BWEBM;
  logic [DATA_W-1:0] Q;

  modport master (output BIST, CEBM, WEBM, AM, DM, BWEBM, input Q);
  modport slave  (input BIST, CEBM, WEBM, AM, DM, BWEBM, output Q);
endinterface

// File: rtl/wq_mem_bist_addr_gen.sv
// rtl/wq_mem_bist_addr_gen.sv - loadable up/down March address counter with end-of-element flag
module wq_mem_bist_addr_gen #(
  parameter int NUM_WORD = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic              load_down,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic down;

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr <= '0;
      down <= 1'b0;
    end else if (load) begin
      down <= load_down;
      addr <= load_down ? ADDR_W'(NUM_WORD - 1) : '0;
    end else if (step) begin
      addr <= down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
    end
  end

  assign last = down ? (addr == '0) : (addr == ADDR_W'(NUM_WORD - 1));

endmodule

// File: rtl/wq_mem_bist.sv
// rtl/wq_mem_bist.sv - March C- BIST controller for the Wq weight SRAM BIST port
// Define WQ_BIST_CHKBD_EN to append a checkerboard-background pass after the all-0 pass.
module wq_mem_bist
  import wq_mem_bist_pkg::*;
#(
  parameter int NUM_WORD = 1024,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 128,
  parameter int RD_LAT   = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [ELEM_W-1:0] fail_elem,
  wq_mem_bist_if.master     mem
);
  localparam int DCNT_W = $clog2(RD_LAT + 2);

  state_t            state;
  logic [2:0]        elem;
  logic              phase;
  logic [DCNT_W-1:0] drain_cnt;
`ifdef WQ_BIST_CHKBD_EN
  logic              pass;
`endif

  logic [ADDR_W-1:0] ag_addr;
  logic              ag_last, ag_load, ag_load_down, ag_step;
  logic              start_ok, has_rd, has_wr, op_rd, addr_done, elem_done, seq_done, last_pass;
  logic [2:0]        next_elem;
  logic [DATA_W-1:0] bg, op_data;
  logic [ELEM_W-1:0] op_tag;

  // Expected-data pipe; stage RD_LAT lines up with the cycle Q is valid.
  logic [RD_LAT:0]   pipe_vld;
  logic [DATA_W-1:0] pipe_exp  [RD_LAT+1];
  logic [ADDR_W-1:0] pipe_addr [RD_LAT+1];
  logic [ELEM_W-1:0] pipe_tag  [RD_LAT+1];

  wq_mem_bist_addr_gen #(.NUM_WORD(NUM_WORD), .ADDR_W(ADDR_W)) u_addr_gen (
    .CLK       (CLK),
    .RST       (RST),
    .load      (ag_load),
    .load_down (ag_load_down),
    .step      (ag_step),
    .addr      (ag_addr),
    .last      (ag_last)
  );

  always_comb begin
    start_ok  = start && (state == IDLE || state == DONE);
    has_rd    = ELEM_HAS_RD[elem];
    has_wr    = ELEM_HAS_WR[elem];
    op_rd     = has_rd && !phase;
    addr_done = !(has_rd && has_wr) || phase;
    elem_done = addr_done && ag_last;
`ifdef WQ_BIST_CHKBD_EN
    last_pass = pass;
    bg        = pass ? {(DATA_W/2){ag_addr[0] ? CHKBD_ODD : CHKBD_EVEN}} : {DATA_W{1'b0}};
    op_tag    = {pass, elem};
`else
    last_pass = 1'b1;
    bg        = {DATA_W{1'b0}};
    op_tag    = elem;
`endif
    seq_done     = elem_done && (elem == LAST_ELEM) && last_pass;
    next_elem    = (elem == LAST_ELEM) ? 3'd0 : elem + 3'd1;
    op_data      = bg ^ {DATA_W{op_rd ? ELEM_RD_INV[elem] : ELEM_WR_INV[elem]}};
    ag_load      = start_ok || (state == MARCH && elem_done && !seq_done);
    ag_load_down = !start_ok && ELEM_DOWN[next_elem];
    ag_step      = (state == MARCH) && addr_done && !elem_done;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      mem.BIST  <= 1'b0;
      mem.CEBM  <= 1'b1;
      mem.WEBM  <= 1'b1;
      mem.AM    <= '0;
      mem.DM    <= '0;
      mem.BWEBM <= '1;
      elem      <= '0;
      phase     <= 1'b0;
      drain_cnt <= '0;
      pipe_vld  <= '0;
`ifdef WQ_BIST_CHKBD_EN
      pass      <= 1'b0;
`endif
    end else begin
      pipe_vld[0]  <= (state == MARCH) && op_rd;
      pipe_exp[0]  <= op_data;
      pipe_addr[0] <= ag_addr;
      pipe_tag[0]  <= op_tag;
      for (int i = 1; i <= RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_exp[i]  <= pipe_exp[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
        pipe_tag[i]  <= pipe_tag[i-1];
      end

      if (pipe_vld[RD_LAT] && mem.Q != pipe_exp[RD_LAT]) begin
        fail <= 1'b1;
        if (!fail) begin
          fail_addr <= pipe_addr[RD_LAT];
          fail_elem <= pipe_tag[RD_LAT];
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state     <= MARCH;
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            mem.BIST  <= 1'b1;
            elem      <= '0;
            phase     <= 1'b0;
`ifdef WQ_BIST_CHKBD_EN
            pass      <= 1'b0;
`endif
          end
        end
        MARCH: begin
          mem.CEBM  <= 1'b0;
          mem.WEBM  <= op_rd;
          mem.BWEBM <= {DATA_W{op_rd}};
          mem.DM    <= op_rd ? {DATA_W{1'b0}} : op_data;
          mem.AM    <= ag_addr;
          phase     <= (has_rd && has_wr) ? !phase : 1'b0;
          if (elem_done) begin
            elem <= next_elem;
`ifdef WQ_BIST_CHKBD_EN
            if (elem == LAST_ELEM) pass <= 1'b1;
`endif
          end
          if (seq_done) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          mem.CEBM  <= 1'b1;
          mem.WEBM  <= 1'b1;
          mem.BWEBM <= '1;
          mem.DM    <= '0;
          mem.AM    <= '0;
          // Hold BIST until the last read has come back and been compared.
          if (drain_cnt == DCNT_W'(RD_LAT + 1)) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            mem.BIST <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + DCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wq_mem_bist.sv
// tb/tb_wq_mem_bist.sv - directed bench for wq_mem_bist with a 1-cycle-latency SRAM model and fault injection
module tb_wq_mem_bist;
  localparam int N  = 1024;
  localparam int AW = 10;
  localparam int DW = 128;
`ifdef WQ_BIST_CHKBD_EN
  localparam int OPS = 20 * N;
  localparam int FEW = 4;
`else
  localparam int OPS = 10 * N;
  localparam int FEW = 3;
`endif
  localparam int RUN = OPS + 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [FEW-1:0] fail_elem;

  int errors;
  int checks;
  int fault_mode;

  wq_mem_bist_if #(.ADDR_W(AW), .DATA_W(DW)) mb ();

  wq_mem_bist #(.NUM_WORD(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .mem       (mb)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] mem_arr [N];
  logic [DW-1:0] q_raw;
  logic [AW-1:0] rd_addr;

  always @(posedge CLK) begin
    if (mb.BIST && !mb.CEBM) begin
      if (!mb.WEBM) mem_arr[mb.AM] <= (mem_arr[mb.AM] & mb.BWEBM) | (mb.DM & ~mb.BWEBM);
      else begin
        q_raw   <= mem_arr[mb.AM];
        rd_addr <= mb.AM;
      end
    end
  end

  always_comb begin
    mb.Q = q_raw;
    if (fault_mode == 1 && rd_addr == 10'h3A7) mb.Q[5] = 1'b1;
    if (fault_mode == 2 && rd_addr == 10'h000) mb.Q[127] = 1'b0;
    if (fault_mode == 3 && rd_addr == 10'h3FF) mb.Q = {DW{1'b1}};
  end

  // Independent enumeration of the March C- op stream by op index (1-based).
  function automatic void exp_op(input int idx, output logic wr, output logic [AW-1:0] a,
                                 output logic [DW-1:0] d);
    int j, k, e, p;
    logic pol;
    logic [DW-1:0] bgv;
    j = idx - 1;
    p = 0;
    if (j >= 10 * N) begin
      p = 1;
      j = j - 10 * N;
    end
    if (j < N) begin
      a = AW'(j); wr = 1'b1; pol = 1'b0;
    end else if (j < 9 * N) begin
      e   = 1 + (j - N) / (2 * N);
      k   = (j - N) % (2 * N);
      a   = (e >= 3) ? AW'(N - 1 - k / 2) : AW'(k / 2);
      wr  = (k % 2) == 1;
      pol = wr ? (e == 1 || e == 3) : (e == 2 || e == 4);
    end else begin
      a = AW'(j - 9 * N); wr = 1'b0; pol = 1'b0;
    end
    bgv = '0;
    if (p == 1) bgv = a[0] ? {64{2'b01}} : {64{2'b10}};
    d = pol ? ~bgv : bgv;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    start = 1'b0;
    step(2);
    RST = 1'b0;
    checks++;
    if ({busy, done, fail, mb.BIST, mb.CEBM, mb.WEBM} !== 6'b000011) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000011", {busy, done, fail, mb.BIST, mb.CEBM, mb.WEBM});
    end
    checks++;
    if ({fail_addr, fail_elem} !== '0) begin
      errors++;
      $display("FAIL reset_fail_info: got addr=%h elem=%h expected 0/0", fail_addr, fail_elem);
    end
    checks++;
    if (mb.AM !== '0) begin
      errors++;
      $display("FAIL reset_am: got %h expected 0", mb.AM);
    end
    checks++;
    if (mb.DM !== {DW{1'b0}}) begin
      errors++;
      $display("FAIL reset_dm: got %h expected 0", mb.DM);
    end
    checks++;
    if (mb.BWEBM !== {DW{1'b1}}) begin
      errors++;
      $display("FAIL reset_bwebm: got %h expected all ones", mb.BWEBM);
    end
  endtask

  task automatic test_fault_free();
    logic          ewr;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    int            op_bad, first_bad;
    logic [AW-1:0] cb_am0, cb_am1;
    logic [DW-1:0] cb_dm0, cb_dm1;
    op_bad = 0;
    first_bad = 0;
    cb_am0 = '1; cb_am1 = '0; cb_dm0 = '0; cb_dm1 = '0;
    fault_mode = 0;
    pulse_start();
    checks++;
    if ({busy, mb.BIST, mb.CEBM, done} !== 4'b1110) begin
      errors++;
      $display("FAIL start_accept: got busy/BIST/CEBM/done=%b expected 1110", {busy, mb.BIST, mb.CEBM, done});
    end
    for (int k = 1; k <= OPS; k++) begin
      step(1);
      exp_op(k, ewr, ea, ed);
      if (mb.CEBM !== 1'b0 || mb.WEBM !== !ewr || mb.AM !== ea ||
          mb.DM !== (ewr ? ed : {DW{1'b0}}) || mb.BWEBM !== {DW{!ewr}}) begin
        op_bad++;
        if (first_bad == 0) first_bad = k;
      end
      if (k == 10 * N + 1) begin cb_am0 = mb.AM; cb_dm0 = mb.DM; end
      if (k == 10 * N + 2) begin cb_am1 = mb.AM; cb_dm1 = mb.DM; end
    end
    checks++;
    if (op_bad !== 0) begin
      errors++;
      $display("FAIL op_sequence: got %0d bad ops (first at op %0d) expected 0", op_bad, first_bad);
    end
`ifdef WQ_BIST_CHKBD_EN
    checks++;
    if (cb_am0 !== 10'd0 || cb_dm0 !== {64{2'b10}}) begin
      errors++;
      $display("FAIL chkbd_even: got am=%h dm=%h expected am=0 dm=aa..a", cb_am0, cb_dm0);
    end
    checks++;
    if (cb_am1 !== 10'd1 || cb_dm1 !== {64{2'b01}}) begin
      errors++;
      $display("FAIL chkbd_odd: got am=%h dm=%h expected am=1 dm=55..5", cb_am1, cb_dm1);
    end
`endif
    step(2);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_early: got done=%b busy=%b expected 0/1", done, busy);
    end
    step(1);
    checks++;
    if ({done, fail, mb.BIST, busy, mb.CEBM} !== 5'b10001) begin
      errors++;
      $display("FAIL done_clean: got done/fail/BIST/busy/CEBM=%b expected 10001", {done, fail, mb.BIST, busy, mb.CEBM});
    end
  endtask

  task automatic test_fault(input string name, input int mode, input logic [AW-1:0] ea,
                            input logic [FEW-1:0] ee);
    fault_mode = mode;
    pulse_start();
    checks++;
    if (fail !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_restart: got fail=%b done=%b busy=%b expected 0/0/1", name, fail, done, busy);
    end
    step(OPS);
    checks++;
    if ({fail, fail_addr, fail_elem} !== {1'b1, ea, ee}) begin
      errors++;
      $display("FAIL %s_mid: got fail=%b addr=%h elem=%0d expected 1/%h/%0d", name, fail, fail_addr, fail_elem, ea, ee);
    end
    step(3);
    checks++;
    if ({done, fail, fail_addr, fail_elem} !== {2'b11, ea, ee}) begin
      errors++;
      $display("FAIL %s_end: got done=%b fail=%b addr=%h elem=%0d expected 1/1/%h/%0d", name, done, fail, fail_addr, fail_elem, ea, ee);
    end
  endtask

  task automatic test_reset_midrun();
    fault_mode = 0;
    pulse_start();
    step(5000);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    checks++;
    if ({mb.CEBM, mb.BIST, busy, done} !== 4'b1000) begin
      errors++;
      $display("FAIL midrun_reset: got CEBM/BIST/busy/done=%b expected 1000", {mb.CEBM, mb.BIST, busy, done});
    end
    pulse_start();
    step(RUN - 1);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL rerun_early: got done=%b expected 0", done);
    end
    step(1);
    checks++;
    if (done !== 1'b1 || fail !== 1'b0) begin
      errors++;
      $display("FAIL rerun_done: got done=%b fail=%b expected 1/0", done, fail);
    end
  endtask

  task automatic test_start_while_busy();
    fault_mode = 0;
    pulse_start();
    step(100);
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || mb.CEBM !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_march: got busy=%b CEBM=%b expected 1/0", busy, mb.CEBM);
    end
    step(OPS - 101);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_drain: got done=%b busy=%b expected 0/1", done, busy);
    end
    step(1);
    checks++;
    if (done !== 1'b1 || fail !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_len: got done=%b fail=%b busy=%b expected 1/0/0", done, fail, busy);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    fault_mode = 0;
    start = 1'b0;
    RST = 1'b1;
    test_reset();
    test_fault_free();
    test_fault("sa1_bit5", 1, 10'h3A7, FEW'(1));
    test_fault("sa0_bit127", 2, 10'h000, FEW'(2));
    test_fault("nowrite_3ff", 3, 10'h3FF, FEW'(1));
    test_reset_midrun();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
